// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, baud counter width, default
// frame shape and a parity helper. Used by both uart_tx and uart_rx.
package uart_pkg;

    localparam int UART_BAUD_W        = 32;
    localparam int UART_DATA_BITS_DEF = 8;
    localparam int UART_STOP_BITS_DEF = 1;

    localparam logic [2:0] UART_ST_IDLE   = 3'd0;
    localparam logic [2:0] UART_ST_START  = 3'd1;
    localparam logic [2:0] UART_ST_DATA   = 3'd2;
    localparam logic [2:0] UART_ST_PARITY = 3'd3;
    localparam logic [2:0] UART_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = UART_ST_IDLE,
        S_START  = UART_ST_START,
        S_DATA   = UART_ST_DATA,
        S_PARITY = UART_ST_PARITY,
        S_STOP   = UART_ST_STOP
    } uart_state_t;

    // Parity over a (zero-extended) character; odd=1 makes the total count of ones odd.
    function automatic logic uart_parity(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Load/decrement bit-period counter. tick is high while the count is zero,
// so a load of N gives a bit that ends N+1 cycles after the load edge.
module uart_baud_cnt
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   load,
    input  logic [UART_BAUD_W-1:0] load_val,
    output logic                   tick
);

    localparam logic [UART_BAUD_W-1:0] CNT_ONE = UART_BAUD_W'(1);

    logic [UART_BAUD_W-1:0] r_count;

    // Reload on request, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    assign tick = (r_count == '0);

endmodule

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit and STOP_BITS stop bits, each baud_div+1 cycles long.
// Optional feature macro: UART_TX_PARITY_EN (adds tx_parity_odd and a parity bit).
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS_DEF,
    parameter int STOP_BITS = UART_STOP_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic                   tx_en,
    input  logic [UART_BAUD_W-1:0] baud_div,
    input  logic                   tx_start,
    input  logic [DATA_BITS-1:0]   tx_data_in,
`ifdef UART_TX_PARITY_EN
    input  logic                   tx_parity_odd,
`endif
    output logic                   tx_serial,
    output logic                   tx_busy,
    output logic                   tx_done_tick
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t            r_state,    w_state_n;
    logic [DATA_BITS-1:0]   r_shift,    w_shift_n;
    logic [IDX_W-1:0]       r_idx,      w_idx_n;
    logic                   r_stop_cnt, w_stop_cnt_n;
    logic [UART_BAUD_W-1:0] r_period,   w_period_n;
    logic                   r_serial,   w_serial_n;
    logic                   r_busy,     w_busy_n;
    logic                   r_done,     w_done_n;
`ifdef UART_TX_PARITY_EN
    logic                   r_parity,   w_parity_n;
`endif

    logic                   w_accept;
    logic                   w_load_frame;
    logic                   w_cnt_load;
    logic [UART_BAUD_W-1:0] w_cnt_load_val;
    logic                   w_tick;

    assign w_accept = tx_en && tx_start;

    uart_baud_cnt u_baud_cnt (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (w_cnt_load),
        .load_val (w_cnt_load_val),
        .tick     (w_tick)
    );

    // Next-state and next-output logic; every bit change reloads the period counter.
    always_comb begin
        w_state_n      = r_state;
        w_shift_n      = r_shift;
        w_idx_n        = r_idx;
        w_stop_cnt_n   = r_stop_cnt;
        w_period_n     = r_period;
        w_serial_n     = r_serial;
        w_busy_n       = r_busy;
        w_done_n       = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_n     = r_parity;
`endif
        w_load_frame   = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = r_period;

        case (r_state)
            S_IDLE: begin
                w_load_frame = w_accept;
            end
            S_START: begin
                if (w_tick) begin
                    w_state_n  = S_DATA;
                    w_idx_n    = '0;
                    w_serial_n = r_shift[0];
                    w_cnt_load = 1'b1;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt_load = 1'b1;
                    if (r_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n  = S_PARITY;
                        w_serial_n = r_parity;
`else
                        w_state_n    = S_STOP;
                        w_serial_n   = 1'b1;
                        w_stop_cnt_n = 1'b0;
`endif
                    end else begin
                        w_idx_n    = r_idx + IDX_ONE;
                        w_shift_n  = r_shift >> 1;
                        w_serial_n = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    w_state_n    = S_STOP;
                    w_serial_n   = 1'b1;
                    w_stop_cnt_n = 1'b0;
                    w_cnt_load   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        // Frame ends here; a start seen on this same edge chains gaplessly.
                        w_done_n = 1'b1;
                        if (w_accept) begin
                            w_load_frame = 1'b1;
                        end else begin
                            w_state_n  = S_IDLE;
                            w_busy_n   = 1'b0;
                            w_serial_n = 1'b1;
                        end
                    end else begin
                        w_stop_cnt_n = ~r_stop_cnt;
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n  = S_IDLE;
                w_busy_n   = 1'b0;
                w_serial_n = 1'b1;
            end
        endcase

        if (w_load_frame) begin
            w_state_n      = S_START;
            w_shift_n      = tx_data_in;
            w_period_n     = baud_div;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = baud_div;
            w_serial_n     = 1'b0;
            w_busy_n       = 1'b1;
`ifdef UART_TX_PARITY_EN
            w_parity_n     = uart_parity(8'(tx_data_in), tx_parity_odd);
`endif
        end
    end

    // Control and output registers; reset aborts any frame with the line high.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_serial   <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_idx      <= w_idx_n;
            r_stop_cnt <= w_stop_cnt_n;
            r_serial   <= w_serial_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
        end
    end

    // Frame data captured at acceptance: shift register, bit period, parity.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_shift  <= '0;
            r_period <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_shift  <= w_shift_n;
            r_period <= w_period_n;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_n;
`endif
        end
    end

    assign tx_serial    = r_serial;
    assign tx_busy      = r_busy;
    assign tx_done_tick = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance with a single stop bit and one
// with two stop bits, each started by its own strobe.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        tx_en = 1'b1;
    logic [31:0] baud_div = 32'd3;
    logic        tx_start = 1'b0;
    logic        tx_start2 = 1'b0;
    logic [7:0]  tx_data_in = 8'h00;
    logic        par_odd = 1'b0;
    logic        ser1, busy1, done1;
    logic        ser2, busy2, done2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .tx_en        (tx_en),
        .baud_div     (baud_div),
        .tx_start     (tx_start),
        .tx_data_in   (tx_data_in),
`ifdef UART_TX_PARITY_EN
        .tx_parity_odd(par_odd),
`endif
        .tx_serial    (ser1),
        .tx_busy      (busy1),
        .tx_done_tick (done1)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk          (clk),
        .arst_n       (arst_n),
        .tx_en        (tx_en),
        .baud_div     (baud_div),
        .tx_start     (tx_start2),
        .tx_data_in   (tx_data_in),
`ifdef UART_TX_PARITY_EN
        .tx_parity_odd(par_odd),
`endif
        .tx_serial    (ser2),
        .tx_busy      (busy2),
        .tx_done_tick (done2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line levels bit by bit (bit 0 = start); everything above the frame body is stop level.
    function automatic logic [15:0] frame_lv(input logic [7:0] d, input logic pb);
        logic [15:0] v;
        v      = '1;
        v[0]   = 1'b0;
        v[8:1] = d;
        if (PAR == 1) v[9] = pb;
        return v;
    endfunction

    // Send one frame and check every cycle of it, then the done pulse.
    // mode 1: pulse tx_start at cycle poke_at; mode 2: change baud_div and drop tx_en there.
    task automatic run_frame(input string tag, input bit sel, input logic [7:0] d,
                             input logic [31:0] div, input logic [15:0] lv, input int nb,
                             input int poke_at, input int mode);
        int p, f, ok_line, bad_busy, bad_done;
        logic s, b, dn;
        p = int'(div) + 1;
        f = nb * p;
        ok_line = 0; bad_busy = 0; bad_done = 0;
        tx_data_in = d;
        baud_div   = div;
        if (sel) tx_start2 = 1'b1; else tx_start = 1'b1;
        step();
        tx_start = 1'b0; tx_start2 = 1'b0;
        for (int i = 0; i < f; i++) begin
            if (i > 0) step();
            s  = sel ? ser2  : ser1;
            b  = sel ? busy2 : busy1;
            dn = sel ? done2 : done1;
            if (s == lv[i / p]) ok_line++;
            if (!b) bad_busy++;
            if (dn) bad_done++;
            tx_start = 1'b0;
            if (i == poke_at) begin
                if (mode == 1) begin
                    tx_start   = 1'b1;
                    tx_data_in = 8'h00;
                end else if (mode == 2) begin
                    baud_div = 32'd0;
                    tx_en    = 1'b0;
                end
            end
        end
        tx_start = 1'b0;
        step();
        chk({tag, "_line"}, ok_line, f);
        chk({tag, "_busy_in_frame"}, bad_busy, 0);
        chk({tag, "_early_done"}, bad_done, 0);
        chk({tag, "_done_at_F"}, sel ? done2 : done1, 1);
        chk({tag, "_busy_at_F"}, sel ? busy2 : busy1, 0);
        chk({tag, "_idle_high"}, sel ? ser2 : ser1, 1);
        step();
        chk({tag, "_done_one_cycle"}, sel ? done2 : done1, 0);
        tx_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int f, cnt, d_first, d_second, d_cnt, ok_line, bad;
        logic [15:0] lv0, lv1;

        // Reset state while reset is held
        #23;
        chk("rst_serial", ser1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst2_serial", ser2, 1);
        chk("rst2_busy", busy2, 0);
        #10 arst_n = 1'b1;
        step();

        // Basic 8'hA5 frame, P = 4
        run_frame("basic", 1'b0, 8'hA5, 32'd3, frame_lv(8'hA5, 1'b0), 10 + PAR, -1, 0);

        // Back-to-back: 8'h00 then 8'hFF, second start sampled on the frame-end edge
        f = (10 + PAR) * 4;
        lv0 = frame_lv(8'h00, 1'b0);
        lv1 = frame_lv(8'hFF, 1'b0);
        ok_line = 0; d_first = -1; d_second = -1; d_cnt = 0;
        tx_data_in = 8'h00; baud_div = 32'd3; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        for (int i = 0; i <= 2 * f; i++) begin
            if (i > 0) step();
            if (i < 2 * f) begin
                if (i < f) begin
                    if (ser1 == lv0[i / 4]) ok_line++;
                end else begin
                    if (ser1 == lv1[(i - f) / 4]) ok_line++;
                end
            end
            if (done1) begin
                d_cnt++;
                if (d_first < 0) d_first = i; else if (d_second < 0) d_second = i;
            end
            tx_start = 1'b0;
            if (i == f - 1) begin
                tx_start   = 1'b1;
                tx_data_in = 8'hFF;
            end
        end
        tx_start = 1'b0;
        chk("b2b_line", ok_line, 2 * f);
        chk("b2b_done_cnt", d_cnt, 2);
        chk("b2b_done1_pos", d_first, f);
        chk("b2b_done2_pos", d_second, 2 * f);
        step();

        // Start pulsed mid-frame is ignored
        run_frame("midstart", 1'b0, 8'hA5, 32'd3, frame_lv(8'hA5, 1'b0), 10 + PAR, 15, 1);
        bad = 0;
        for (int i = 0; i < 2 * f; i++) begin
            step();
            if (done1 || busy1 || !ser1) bad++;
        end
        chk("midstart_no_second_frame", bad, 0);

        // Start with tx_en low is ignored
        tx_en = 1'b0; tx_data_in = 8'h00; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy1 || !ser1 || done1) bad++;
            step();
        end
        chk("en_low_ignored", bad, 0);
        tx_en = 1'b1;

        // Asynchronous reset in the middle of data bit 3 (level 0 for 8'hA5)
        tx_data_in = 8'hA5; baud_div = 32'd3; tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (17) step();
        chk("rstmid_pre_line", ser1, 0);
        chk("rstmid_pre_busy", busy1, 1);
        #2 arst_n = 1'b0;
        #1;
        chk("rstmid_line_high", ser1, 1);
        chk("rstmid_busy_low", busy1, 0);
        step();
        step();
        #2 arst_n = 1'b1;
        bad = 0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (done1) cnt++;
            if (!ser1 || busy1) bad++;
        end
        chk("rstmid_no_done", cnt, 0);
        chk("rstmid_stays_idle", bad, 0);

        // baud_div = 0: one bit per cycle
        run_frame("div0", 1'b0, 8'h3C, 32'd0, frame_lv(8'h3C, 1'b0), 10 + PAR, -1, 0);

        // baud_div and tx_en changed mid-frame do not affect the frame in flight
        run_frame("divchg", 1'b0, 8'hA5, 32'd3, frame_lv(8'hA5, 1'b0), 10 + PAR, 10, 2);

`ifdef UART_TX_PARITY_EN
        // A5 has four ones: even parity bit 0, odd parity bit 1
        par_odd = 1'b0;
        run_frame("par_even", 1'b0, 8'hA5, 32'd3, frame_lv(8'hA5, 1'b0), 11, -1, 0);
        par_odd = 1'b1;
        run_frame("par_odd", 1'b0, 8'hA5, 32'd3, frame_lv(8'hA5, 1'b1), 11, -1, 0);
        par_odd = 1'b0;
`endif

        // Two stop bits on the second instance
        run_frame("stop2", 1'b1, 8'hA5, 32'd3, frame_lv(8'hA5, 1'b0), 11 + PAR, -1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
